sys_rst_seq: RTL and testbench
==============================

# sys_rst_seq

Reset sequencer that consumes the MMCM `locked` indication from the system clock generator and produces ordered, glitch-free resets for the 100 MHz domain. It runs on `clk_100m`, synchronises `locked`, and waits for a programmable stable period. It then releases the core reset, followed by the peripheral reset. On any later loss of lock it re-asserts both resets and re-runs the sequence, counting lock-loss events for debug.

## Interface

- `STABLE_CYCLES`, default 1024: cycles `locked` must stay high before `rst_core` is released. Must be ≥ 1.
- `PERIPH_DELAY`, default 16: cycles between `rst_core` release and `rst_periph` release. Must be ≥ 1.
- `clk_100m` input, 1 bit: single clock for all logic.
- `rst` input, 1 bit: synchronous, active-high reset.
- `locked` input, 1 bit: MMCM lock. Asynchronous to `clk_100m` and treated as such.
- `soft_rst_req` input, 1 bit: single-cycle request to re-run the sequence.
- `rst_core` output, 1 bit: active-high core reset. Registered.
- `rst_periph` output, 1 bit: active-high peripheral reset. Registered.
- `sys_ready` output, 1 bit: high only in RUN.
- `lock_loss_cnt` output, 8 bits: saturating count of lock losses after core release.

## Operation

- `locked` passes through a 2-flop synchroniser, producing `locked_s`. Both flops reset to 0.
- One down-counter or up-counter `cnt` is shared by all states. Its width is `$clog2(max(STABLE_CYCLES, PERIPH_DELAY))`, minimum 1 bit.
- Moore FSM; outputs are decoded from the state register only:
  - **WAIT_LOCK** (reset state): `rst_core=1`, `rst_periph=1`, `sys_ready=0`, `cnt=0`. If `locked_s=1`, go to STABLE.
  - **STABLE**: same outputs as WAIT_LOCK. `cnt` increments each cycle. If `locked_s=0`, go to WAIT_LOCK and clear `cnt`; this does not count as a lock loss. If `cnt==STABLE_CYCLES-1`, go to REL_CORE and clear `cnt`.
  - **REL_CORE**: `rst_core=0`, `rst_periph=1`. `cnt` increments. If `cnt==PERIPH_DELAY-1`, go to RUN.
  - **RUN**: `rst_core=0`, `rst_periph=0`, `sys_ready=1`. Holds until an exit event.
- Exit events in REL_CORE or RUN, in priority order:
  1. `locked_s=0`: go to WAIT_LOCK and increment `lock_loss_cnt`, saturating at 255.
  2. `soft_rst_req=1`: go to WAIT_LOCK. `lock_loss_cnt` is unchanged.
- If lock loss and `soft_rst_req` occur in the same cycle, the lock-loss path wins and the counter increments once.
- `soft_rst_req` is ignored in WAIT_LOCK and STABLE.
- `rst` reset values: state WAIT_LOCK, `cnt=0`, `rst_core=1`, `rst_periph=1`, `sys_ready=0`, `lock_loss_cnt=0`, synchroniser flops 0.
- `rst` asserted mid-sequence returns the block to the reset values on the next edge, regardless of state.

## Timing

- Edge 0 is the first edge at which `locked` is sampled high by the first synchroniser flop.
  - `locked_s=1` after edge 1.
  - State becomes STABLE after edge 2.
  - `rst_core` falls after edge `STABLE_CYCLES+2`.
- `rst_periph` and `sys_ready` change exactly `PERIPH_DELAY` edges after `rst_core` falls.
- Lock-loss latency: `locked` sampled low at edge M asserts both resets and deasserts `sys_ready` after edge M+2. `lock_loss_cnt` updates on the same edge.
- `soft_rst_req` sampled at edge K asserts both resets after edge K. If `locked_s` is still high, the sequence restarts: STABLE after edge K+1, `rst_core` release after edge `K+1+STABLE_CYCLES`.
- A `locked` high pulse of 1 cycle may be missed by the synchroniser; no release occurs without `STABLE_CYCLES` of continuous `locked_s`.
- `rst_core` and `rst_periph` never glitch. `rst_periph=0` with `rst_core=1` never occurs.

## Configuration

- `SYS_RST_SEQ_LOSS_CNT_EN` defined: `lock_loss_cnt` counter is implemented as described.
- `SYS_RST_SEQ_LOSS_CNT_EN` undefined: counter logic is removed and `lock_loss_cnt` is tied to 8'h00. All other behaviour is identical.

## Test plan

Bench parameters: `STABLE_CYCLES=8`, `PERIPH_DELAY=4`.

- **Power-up:** `rst=1` for 3 cycles, `locked=0` → `rst_core=1`, `rst_periph=1`, `sys_ready=0`, `lock_loss_cnt=0`. These hold indefinitely while `locked=0`.
- **Normal release:** `locked` rises, first sampled at edge 0 → `rst_core` falls after edge 10; `rst_periph` falls and `sys_ready` rises after edge 14.
- **Lock glitch during STABLE:** `locked` low for 3 cycles at STABLE `cnt=5` → returns to WAIT_LOCK with resets held. The full 8-cycle window restarts. `lock_loss_cnt` stays 0.
- **Lock loss in RUN:** drop `locked` at edge M → both resets are 1 and `lock_loss_cnt=1` after edge M+2. Re-lock repeats the 10/4-cycle release.
- **Simultaneous events and saturation:** `soft_rst_req` in the same cycle as the lock loss reaches RUN → counter increments by exactly 1. 300 lock-loss cycles from RUN → `lock_loss_cnt=255`. With `SYS_RST_SEQ_LOSS_CNT_EN` undefined, the counter reads 0 throughout.
- **Mid-sequence reset:** `rst=1` during REL_CORE → after the next edge `rst_core=1`, state is WAIT_LOCK, and `lock_loss_cnt=0`.

Source files
------------

// File: rtl/sys_rst_seq_if.sv
// Reset-sequencer bus: MMCM lock and soft request in, ordered resets and status out.
// The master side is the sequencer itself; the slave side is the consumer of the resets.
interface sys_rst_seq_if;
  logic       locked;
  logic       soft_rst_req;
  logic       rst_core;
  logic       rst_periph;
  logic       sys_ready;
  logic [7:0] lock_loss_cnt;

  modport master (
    input  locked,
    input  soft_rst_req,
    output rst_core,
    output rst_periph,
    output sys_ready,
    output lock_loss_cnt
  );

  modport slave (
    output locked,
    output soft_rst_req,
    input  rst_core,
    input  rst_periph,
    input  sys_ready,
    input  lock_loss_cnt
  );
endinterface

// File: rtl/sys_rst_seq.sv
// Lock-driven reset sequencer: waits for stable MMCM lock, releases core then peripheral reset.
// Define SYS_RST_SEQ_LOSS_CNT_EN to build the saturating lock-loss debug counter.
module sys_rst_seq #(
  parameter int STABLE_CYCLES = 1024,
  parameter int PERIPH_DELAY  = 16
) (
  input  logic          clk_100m,
  input  logic          rst,
  sys_rst_seq_if.master bus
);

  localparam int MAX_CNT = (STABLE_CYCLES > PERIPH_DELAY) ? STABLE_CYCLES : PERIPH_DELAY;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DELAY - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    REL_CORE  = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             locked_meta_reg;
  logic             locked_s_reg;
  logic             rst_core_reg;
  logic             rst_periph_reg;
  logic             sys_ready_reg;

  // locked comes from the MMCM with no relation to clk_100m
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      locked_meta_reg <= 1'b0;
      locked_s_reg    <= 1'b0;
    end else begin
      locked_meta_reg <= bus.locked;
      locked_s_reg    <= locked_meta_reg;
    end
  end

  // Outputs are loaded together with the next state so they are glitch-free flops.
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      state_reg      <= WAIT_LOCK;
      cnt_reg        <= '0;
      rst_core_reg   <= 1'b1;
      rst_periph_reg <= 1'b1;
      sys_ready_reg  <= 1'b0;
    end else begin
      case (state_reg)
        WAIT_LOCK: begin
          cnt_reg <= '0;
          if (locked_s_reg) begin
            state_reg <= STABLE;
          end
        end
        STABLE: begin
          if (!locked_s_reg) begin
            state_reg <= WAIT_LOCK;
            cnt_reg   <= '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_reg    <= REL_CORE;
            cnt_reg      <= '0;
            rst_core_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        REL_CORE: begin
          if (!locked_s_reg || bus.soft_rst_req) begin
            state_reg      <= WAIT_LOCK;
            cnt_reg        <= '0;
            rst_core_reg   <= 1'b1;
            rst_periph_reg <= 1'b1;
            sys_ready_reg  <= 1'b0;
          end else if (cnt_reg == PERIPH_LAST) begin
            state_reg      <= RUN;
            cnt_reg        <= '0;
            rst_periph_reg <= 1'b0;
            sys_ready_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        RUN: begin
          cnt_reg <= '0;
          if (!locked_s_reg || bus.soft_rst_req) begin
            state_reg      <= WAIT_LOCK;
            rst_core_reg   <= 1'b1;
            rst_periph_reg <= 1'b1;
            sys_ready_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg      <= WAIT_LOCK;
          cnt_reg        <= '0;
          rst_core_reg   <= 1'b1;
          rst_periph_reg <= 1'b1;
          sys_ready_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rst_core   = rst_core_reg;
  assign bus.rst_periph = rst_periph_reg;
  assign bus.sys_ready  = sys_ready_reg;

`ifdef SYS_RST_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt_reg;
  logic       loss_event;

  // Only a loss after core release counts; a drop during STABLE is just an unsettled MMCM.
  assign loss_event = !locked_s_reg && ((state_reg == REL_CORE) || (state_reg == RUN));

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      loss_cnt_reg <= 8'h00;
    end else if (loss_event && (loss_cnt_reg != 8'hFF)) begin
      loss_cnt_reg <= loss_cnt_reg + 8'h01;
    end
  end

  assign bus.lock_loss_cnt = loss_cnt_reg;
`else
  assign bus.lock_loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_sys_rst_seq.sv
// Self-checking bench for sys_rst_seq: directed scenarios plus random lock/soft-request traffic
// compared every cycle against a streak-count reference model.
module tb_sys_rst_seq;
  localparam int S = 8;
  localparam int P = 4;
`ifdef SYS_RST_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic clk_100m;
  logic rst;
  sys_rst_seq_if bus ();

  sys_rst_seq #(.STABLE_CYCLES(S), .PERIPH_DELAY(P)) dut (
    .clk_100m (clk_100m),
    .rst      (rst),
    .bus      (bus.master)
  );

  initial clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;

  int n_vec  = 0;
  int n_fail = 0;

  // Model: two-sample lock delay, then a count of consecutive lock-good edges since last restart.
  logic m_sync1 = 1'b0;
  logic m_sync2 = 1'b0;
  int   m_streak = 0;
  int   m_loss   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_edge(input logic lk, input logic sr, input logic rs);
    logic ls;
    bit   released;
    if (rs) begin
      m_sync1  = 1'b0;
      m_sync2  = 1'b0;
      m_streak = 0;
      m_loss   = 0;
    end else begin
      ls       = m_sync2;
      released = (m_streak >= S + 1);
      if (!ls) begin
        if (released && m_loss < 255) m_loss++;
        m_streak = 0;
      end else if (sr && released) begin
        m_streak = 0;
      end else if (m_streak < 100000) begin
        m_streak++;
      end
      m_sync2 = m_sync1;
      m_sync1 = lk;
    end
  endtask

  task automatic step(input logic lk, input logic sr, input logic rs);
    logic e_core, e_periph;
    bus.locked       = lk;
    bus.soft_rst_req = sr;
    rst              = rs;
    @(posedge clk_100m);
    model_edge(lk, sr, rs);
    #1;
    e_core   = (m_streak < S + 1);
    e_periph = (m_streak < S + 1 + P);
    check("rst_core",      {7'd0, bus.rst_core},   {7'd0, e_core});
    check("rst_periph",    {7'd0, bus.rst_periph}, {7'd0, e_periph});
    check("sys_ready",     {7'd0, bus.sys_ready},  {7'd0, ~e_periph});
    check("lock_loss_cnt", bus.lock_loss_cnt,      LOSS_EN ? 8'(m_loss) : 8'h00);
  endtask

  initial begin
    bus.locked       = 1'b0;
    bus.soft_rst_req = 1'b0;
    rst              = 1'b1;

    // Power-up: reset, then hold with no lock
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
    check("pwrup_core", {7'd0, bus.rst_core}, 8'd1);

    // Normal release: edge 0 is the first step with locked high
    for (int i = 0; i <= 14; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i == 9)  check("core_held_e9", {7'd0, bus.rst_core}, 8'd1);
      if (i == 10) check("core_rel_e10", {7'd0, bus.rst_core}, 8'd0);
      if (i == 13) check("ready_e13",    {7'd0, bus.sys_ready}, 8'd0);
      if (i == 14) check("ready_e14",    {7'd0, bus.sys_ready}, 8'd1);
    end

    // Lock loss in RUN: resets return two edges after locked is sampled low
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("loss_m1_core", {7'd0, bus.rst_core}, 8'd0);
    step(1'b0, 1'b0, 1'b0);
    check("loss_m2_core", {7'd0, bus.rst_core}, 8'd1);
    check("loss_m2_cnt", bus.lock_loss_cnt, LOSS_EN ? 8'd1 : 8'd0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);

    // Lock glitch while STABLE cnt=5: no loss counted, window restarts
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
    check("glitch_cnt", bus.lock_loss_cnt, LOSS_EN ? 8'd1 : 8'd0);

    // Soft request coinciding with the loss reaching the FSM: one increment only
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("simul_cnt", bus.lock_loss_cnt, LOSS_EN ? 8'd2 : 8'd0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);

    // Plain soft request from RUN, then a mid-REL_CORE reset
    step(1'b1, 1'b1, 1'b0);
    check("soft_core", {7'd0, bus.rst_core}, 8'd1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("midrst_core", {7'd0, bus.rst_core}, 8'd1);
    check("midrst_cnt", bus.lock_loss_cnt, 8'd0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);

    // Saturation: 300 lock losses from RUN
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0);
    end
    check("sat_cnt", bus.lock_loss_cnt, LOSS_EN ? 8'd255 : 8'd0);

    // Random traffic: lock runs of random length, sporadic soft requests and resets
    for (int n = 0; n < 250; n++) begin
      logic lk;
      int   len;
      lk  = 1'($urandom_range(0, 1));
      len = (lk && $urandom_range(0, 3) == 0) ? int'($urandom_range(12, 24)) : int'($urandom_range(1, 10));
      for (int i = 0; i < len; i++) begin
        step(lk, ($urandom_range(0, 15) == 0), ($urandom_range(0, 399) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
